dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that sits directly downstream of the Riscv150 core's `dcache_*` memory ports and upstream of the off-chip memory request interface. It serves core loads from a local line store, forwards every store to memory, and drives the core's `stall` input while a miss fill or store is outstanding. Hits return data one cycle after the request, matching block-RAM read timing.

---
 rtl/dcache_ctrl_pkg.sv | 22 ++
 rtl/dcache_data_array.sv | 38 +++
 rtl/dcache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// ============================================================================
// dcache_ctrl_pkg : shared state encoding and line geometry for dcache_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

package dcache_ctrl_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int LINE_OFF_W = OFF_W + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_FILL = 2'd2,
    S_WR_REQ  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_data_array.sv
// ============================================================================
// dcache_data_array : LINES x 4 x 32 line store, byte-masked write port and
// combinational read port for hit lookup.  Revision 1.0
// ============================================================================
`default_nettype none

module dcache_data_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [3:0]       wr_mask_i,
  input  logic [31:0]      wr_data_i
);

  logic [31:0] mem_q [LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_i[b]) mem_q[{wr_idx_i, wr_off_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = mem_q[{rd_idx_i, rd_off_i}];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped, write-through, no-write-allocate data cache
// between the core dcache ports and the memory request interface. Revision 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int ADDR_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - LINE_OFF_W - IDX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          mask_q, mask_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         dout_q, dout_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];

  logic [OFF_W-1:0]    req_off, lat_off, arr_off;
  logic [IDX_W-1:0]    req_idx, lat_idx, arr_idx;
  logic [TAG_W-1:0]    req_tag, lat_tag;
  logic                hit, arr_we, fill_done;
  logic [3:0]          arr_mask;
  logic [31:0]         arr_wdata, rd_data;
  logic                unused_addr;

  assign req_off = dcache_addr[3:2];
  assign req_idx = dcache_addr[LINE_OFF_W +: IDX_W];
  assign req_tag = dcache_addr[LINE_OFF_W+IDX_W +: TAG_W];
  assign lat_off = addr_q[3:2];
  assign lat_idx = addr_q[LINE_OFF_W +: IDX_W];
  assign lat_tag = addr_q[LINE_OFF_W+IDX_W +: TAG_W];
  assign unused_addr = ^dcache_addr;

  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  dcache_data_array #(.LINES(LINES), .IDX_W(IDX_W)) u_data (
    .clk       (clk),
    .rd_idx_i  (req_idx),
    .rd_off_i  (req_off),
    .rd_data_o (rd_data),
    .wr_en_i   (arr_we),
    .wr_idx_i  (arr_idx),
    .wr_off_i  (arr_off),
    .wr_mask_i (arr_mask),
    .wr_data_i (arr_wdata)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    arr_we    = 1'b0;
    arr_idx   = lat_idx;
    arr_off   = cnt_q;
    arr_mask  = 4'hF;
    arr_wdata = mem_resp_data;
    fill_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|dcache_we) begin
          state_d = S_WR_REQ;
          addr_d  = dcache_addr[ADDR_W-1:2];
          data_d  = dcache_din;
          mask_d  = dcache_we;
          if (hit) begin
            arr_we    = 1'b1;
            arr_idx   = req_idx;
            arr_off   = req_off;
            arr_mask  = dcache_we;
            arr_wdata = dcache_din;
          end
        end else if (dcache_re) begin
          if (hit) begin
            dout_d = rd_data;
          end else begin
            state_d = S_RD_REQ;
            addr_d  = dcache_addr[ADDR_W-1:2];
          end
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RD_FILL;
          cnt_d   = '0;
        end
      end
      S_RD_FILL: begin
        if (mem_resp_valid) begin
          arr_we = 1'b1;
          if (cnt_q == lat_off) dout_d = mem_resp_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_WR_REQ: begin
        if (mem_req_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      if (fill_done) valid_q[lat_idx] <= 1'b1;
    end
  end

  // Tags need no reset: they are only trusted behind a set valid bit.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[lat_idx] <= lat_tag;
  end

  assign stall         = (state_q != S_IDLE);
  assign dcache_dout   = dout_q;
  assign mem_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_req_rnw   = (state_q == S_RD_REQ);
  assign mem_req_addr  = (state_q == S_RD_REQ) ? {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} :
                         (state_q == S_WR_REQ) ? {addr_q, 2'b00} : '0;
  assign mem_req_data  = (state_q == S_WR_REQ) ? data_q : '0;
  assign mem_req_mask  = (state_q == S_WR_REQ) ? mask_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// tb_dcache_ctrl : scoreboard bench for dcache_ctrl load/store/fill behaviour
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dcache_addr, dcache_din, dcache_dout, mem_req_data, mem_resp_data;
  logic        dcache_re, stall, mem_req_valid, mem_req_ready, mem_req_rnw, mem_resp_valid;
  logic [3:0]  dcache_we, mem_req_mask;
  logic [27:0] mem_req_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;
  bit          seen, sok;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(64), .ADDR_W(28)) dut (
    .clk(clk), .rst(rst),
    .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [31:0] a);
    dcache_re = 1'b1; dcache_addr = a;
    tick();
    dcache_re = 1'b0;
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    dcache_we = m; dcache_addr = a; dcache_din = d;
    tick();
    dcache_we = 4'h0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic handshake();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic fill(input logic [127:0] line, output bit stall_ok);
    stall_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = line[32*i +: 32];
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (stall !== 1'b0 || dcache_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_core: stall=%b dout=%h, want 0/0", stall, dcache_dout);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_rnw !== 1'b0 || mem_req_addr !== 28'h0 ||
        mem_req_data !== 32'h0 || mem_req_mask !== 4'h0) begin
      errors++;
      $display("FAIL reset_mem: valid=%b rnw=%b addr=%h data=%h mask=%h, want all 0",
               mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_load();
    exp_q.push_back(32'hA2);
    issue_load(32'h0000_1008);
    wait_req(seen);
    checks++;
    if (!seen || mem_req_rnw !== 1'b1 || mem_req_addr !== 28'h000_1000) begin
      errors++;
      $display("FAIL cold_req: seen=%b rnw=%b addr=%h, want 1/1/0001000", seen, mem_req_rnw, mem_req_addr);
    end
    handshake();
    fill({32'hA3, 32'hA2, 32'hA1, 32'hA0}, sok);
    checks++;
    if (!sok) begin errors++; $display("FAIL cold_stall_beats: stall dropped during fill, want 1"); end
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL cold_done: stall=%b req_valid=%b, want 0/0", stall, mem_req_valid);
    end
    exp = exp_q.pop_front();
    checks++;
    if (dcache_dout !== exp) begin errors++; $display("FAIL cold_dout: got %h want %h", dcache_dout, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h1000, 32'h1004, 32'h100C};
    logic [31:0] vals  [3] = '{32'hA0, 32'hA1, 32'hA3};
    for (int i = 0; i < 3; i++) exp_q.push_back(vals[i]);
    dcache_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dcache_addr = addrs[i];
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (dcache_dout !== exp || stall !== 1'b0 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hit[%0d]: dout=%h stall=%b req=%b, want %h/0/0", i, dcache_dout, stall, mem_req_valid, exp);
      end
    end
    dcache_re = 1'b0;
  endtask

  task automatic test_store_hit();
    issue_store(32'h1004, 4'b0010, 32'h0000_5500);
    checks++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_rnw !== 1'b0 || mem_req_addr !== 28'h000_1004 ||
        mem_req_data !== 32'h0000_5500 || mem_req_mask !== 4'b0010) begin
      errors++;
      $display("FAIL store_hit_req: stall=%b v=%b rnw=%b addr=%h data=%h mask=%b, want 1/1/0/0001004/00005500/0010",
               stall, mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask);
    end
    handshake();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL store_hit_cost: stall=%b want 0", stall); end
    exp_q.push_back(32'h0000_55A1);
    issue_load(32'h1004);
    exp = exp_q.pop_front();
    checks++;
    if (dcache_dout !== exp || mem_req_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL store_hit_readback: dout=%h req=%b stall=%b, want %h/0/0", dcache_dout, mem_req_valid, stall, exp);
    end
  endtask

  task automatic test_store_miss();
    issue_store(32'h2000, 4'hF, 32'hDEAD_BEEF);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_rnw !== 1'b0 || mem_req_addr !== 28'h000_2000 || mem_req_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_miss_req: v=%b rnw=%b addr=%h data=%h, want 1/0/0002000/deadbeef",
               mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data);
    end
    handshake();
    exp_q.push_back(32'hA0);
    issue_load(32'h1000);
    exp = exp_q.pop_front();
    checks++;
    if (dcache_dout !== exp || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL store_miss_noalloc: dout=%h req=%b, want %h/0", dcache_dout, mem_req_valid, exp);
    end
    exp_q.push_back(32'hB0);
    issue_load(32'h2000);
    wait_req(seen);
    checks++;
    if (!seen || mem_req_rnw !== 1'b1 || mem_req_addr !== 28'h000_2000) begin
      errors++;
      $display("FAIL store_miss_load_req: seen=%b rnw=%b addr=%h, want 1/1/0002000", seen, mem_req_rnw, mem_req_addr);
    end
    handshake();
    fill({32'hB3, 32'hB2, 32'hB1, 32'hB0}, sok);
    exp = exp_q.pop_front();
    checks++;
    if (!sok || dcache_dout !== exp || stall !== 1'b0) begin
      errors++;
      $display("FAIL store_miss_fill: stall_ok=%b dout=%h stall=%b, want 1/%h/0", sok, dcache_dout, stall, exp);
    end
  endtask

  task automatic test_ready_stall();
    exp_q.push_back(32'hC2);
    issue_load(32'h3008);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (stall !== 1'b1 || mem_req_valid !== 1'b1 || mem_req_rnw !== 1'b1 || mem_req_addr !== 28'h000_3000) begin
        errors++;
        $display("FAIL ready_hold[%0d]: stall=%b v=%b rnw=%b addr=%h, want 1/1/1/0003000",
                 i, stall, mem_req_valid, mem_req_rnw, mem_req_addr);
      end
      tick();
    end
    handshake();
    fill({32'hC3, 32'hC2, 32'hC1, 32'hC0}, sok);
    exp = exp_q.pop_front();
    checks++;
    if (!sok || dcache_dout !== exp || stall !== 1'b0) begin
      errors++;
      $display("FAIL ready_fill: stall_ok=%b dout=%h stall=%b, want 1/%h/0", sok, dcache_dout, stall, exp);
    end
  endtask

  task automatic test_reset_mid_fill();
    issue_load(32'h4004);
    wait_req(seen);
    handshake();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD0;
    tick();
    mem_resp_data = 32'hD1;
    tick();
    mem_resp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (stall !== 1'b0 || dcache_dout !== 32'h0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL midfill_reset: stall=%b dout=%h req=%b, want 0/0/0", stall, dcache_dout, mem_req_valid);
    end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    tick();
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dcache_dout !== 32'h0) begin
      errors++;
      $display("FAIL midfill_stray: stall=%b req=%b dout=%h, want 0/0/0", stall, mem_req_valid, dcache_dout);
    end
    exp_q.push_back(32'hE1);
    issue_load(32'h4004);
    wait_req(seen);
    checks++;
    if (!seen || mem_req_rnw !== 1'b1 || mem_req_addr !== 28'h000_4000) begin
      errors++;
      $display("FAIL midfill_remiss: seen=%b rnw=%b addr=%h, want 1/1/0004000", seen, mem_req_rnw, mem_req_addr);
    end
    handshake();
    fill({32'hE3, 32'hE2, 32'hE1, 32'hE0}, sok);
    exp = exp_q.pop_front();
    checks++;
    if (dcache_dout !== exp) begin errors++; $display("FAIL midfill_refill: got %h want %h", dcache_dout, exp); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3] = '{32'h1000, 32'h1400, 32'h1000};
    logic [127:0] lines [3] = '{{32'hF3, 32'hF2, 32'hF1, 32'hF0},
                                {32'h63, 32'h62, 32'h61, 32'h60},
                                {32'hF3, 32'hF2, 32'hF1, 32'hF0}};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(lines[i][31:0]);
      issue_load(addrs[i]);
      wait_req(seen);
      checks++;
      if (!seen || mem_req_rnw !== 1'b1 || mem_req_addr !== addrs[i][27:0]) begin
        errors++;
        $display("FAIL conflict_req[%0d]: seen=%b rnw=%b addr=%h, want 1/1/%h", i, seen, mem_req_rnw, mem_req_addr, addrs[i][27:0]);
      end
      handshake();
      fill(lines[i], sok);
      exp = exp_q.pop_front();
      checks++;
      if (dcache_dout !== exp || stall !== 1'b0) begin
        errors++;
        $display("FAIL conflict_dout[%0d]: dout=%h stall=%b, want %h/0", i, dcache_dout, stall, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; dcache_addr = 32'h0; dcache_re = 1'b0; dcache_we = 4'h0; dcache_din = 32'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    test_reset();
    test_cold_load();
    test_back_to_back();
    test_store_hit();
    test_store_miss();
    test_ready_stall();
    test_reset_mid_fill();
    test_conflict();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
